node_evaluator: RTL and testbench
=================================

Name: node_evaluator

Overview:
- Datapath partner of the tree-walk controller: holds one spike feature vector for the whole traversal of the decision tree.
- Consumes the controller's serial coefficient stream (load_bias, coeff, is_one, bias) and accumulates bias + Σ coeff·feature for the current node.
- Returns child_direction (sign of the sum) to the controller.
- Releases the held vector when the controller reports cluster completion.

Parameters:
- FEATURES, 3, features per spike vector and terms per node evaluation.
- FEATURE_BIT_DEPTH, 8, signed two's-complement width of each feature.
- COEFF_BIT_DEPTH, 4, signed coefficient width.
- BIAS_BIT_DEPTH, 10, signed bias width.
- ACC_W (localparam), max(FEATURE_BIT_DEPTH+COEFF_BIT_DEPTH, BIAS_BIT_DEPTH) + $clog2(FEATURES+1), accumulator width; sized so overflow cannot occur.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  feature vector offered.
- in_ready  out  1  block can accept a vector; high only in IDLE.
- in_features  in  FEATURES*FEATURE_BIT_DEPTH  feature 0 in LSBs.
- load_bias  in  1  first term of a node evaluation; bias is valid this cycle.
- term_valid  in  1  coeff/is_one valid this cycle. Must be high with load_bias.
- coeff  in  COEFF_BIT_DEPTH  signed coefficient for the current feature.
- is_one  in  1  current coefficient is exactly +1; coeff is ignored.
- bias  in  BIAS_BIT_DEPTH  signed node bias.
- cluster_done  in  1  controller traversal finished (controller out_valid).
- child_direction  out  1  1 = sum ≥ 0 (go right), 0 = sum < 0 (go left).
- decision_valid  out  1  one-cycle pulse when child_direction updates.
- acc_out  out  ACC_W  final signed sum of the last evaluation.
- protocol_error  out  1  one-cycle pulse on an illegal stream event.

Behaviour:
- Reset asserted:
  - State goes to IDLE immediately (asynchronous).
  - child_direction, decision_valid, protocol_error, acc_out, accumulator, term index and feature register all clear to 0.
  - in_ready goes to 1 immediately, because in_ready is combinational on state.
- Reset deasserts synchronously to clk.
- States:
  - IDLE → HOLD: on in_valid & in_ready, register in_features.
  - HOLD → ACCUM: on load_bias & term_valid.
  - ACCUM → HOLD: after the term with index FEATURES-1.
  - HOLD or ACCUM → IDLE: on cluster_done.
- Term arithmetic:
  - Term k = sign-extended feature[k] if is_one, else feature[k] × coeff (signed full product), sign-extended to ACC_W.
  - On load_bias, the accumulator is loaded with sign-extended bias + term 0, and the index becomes 1.
  - On each later term_valid, the accumulator is incremented by term[index], and index increments.
- Completion:
  - At the clock edge that consumes term FEATURES-1, the following are registered from the next-sum value (no extra cycle):
    - child_direction ← ~next_sum[ACC_W-1]
    - acc_out ← next_sum
    - decision_valid ← 1
  - decision_valid is therefore high for exactly the cycle after the last term.
  - child_direction and acc_out hold until the next decision.
  - Latency from load_bias to decision_valid = FEATURES cycles.
- FEATURES=1: load_bias completes the evaluation in the same edge.
- Boundary conditions:
  - load_bias in ACCUM: restart from term 0 with the new bias; pulse protocol_error.
  - term_valid without load_bias in HOLD: ignore; pulse protocol_error.
  - term_valid or load_bias in IDLE: ignore; pulse protocol_error.
  - term_valid low in ACCUM: stall; accumulator and index hold, no timeout.
  - cluster_done in ACCUM: abort; no decision_valid; go to IDLE.
  - cluster_done coincident with the last term: the decision still completes (decision_valid pulses), then go to IDLE.
  - in_valid coincident with cluster_done: not accepted that cycle (in_ready is low); accepted the following cycle at the earliest.
  - Feature register is stable from HOLD until IDLE.
  - in_features changes outside acceptance have no effect.
  - Reset mid-ACCUM: all state cleared; the partial sum is discarded.

Test Plan:
- Reset with in_valid high, then release reset -> in_ready=1 throughout reset; vector accepted on the first edge after release; in_ready=0 next cycle.
- FEATURES=3, features (10,-5,3), bias -20, terms {is_one, coeff 2, coeff -1} on 3 consecutive cycles -> acc_out=-23, child_direction=0, decision_valid pulses exactly 3 cycles after load_bias.
- Same vector, bias 40, coeffs {-1, is_one, 7} -> acc_out=40-10-5+21=46, child_direction=1; repeated for 3 nodes without reloading -> features unchanged.
- Extremes, features (-128,-128,-128), coeffs {-8,-8,-8}, bias 511 -> acc_out=3583 with no wrap; all +127 × -8 with bias -512 -> acc_out=-3560.
- term_valid dropped for 2 cycles mid-node -> result identical to the unstalled case, with decision_valid delayed by 2 cycles.
- Stream errors: load_bias at term index 1 -> protocol_error pulse and restart gives the correct new sum. cluster_done at term index 1 -> no decision_valid, return to IDLE. term_valid in IDLE -> protocol_error, state unchanged.

Source files
------------

// File: rtl/node_evaluator.sv
// Node evaluator: holds one feature vector per tree traversal and accumulates
// bias + sum(coeff * feature) from the controller's serial term stream.
module node_evaluator #(
    parameter int FEATURES          = 3,
    parameter int FEATURE_BIT_DEPTH = 8,
    parameter int COEFF_BIT_DEPTH   = 4,
    parameter int BIAS_BIT_DEPTH    = 10,
    localparam int PROD_W = FEATURE_BIT_DEPTH + COEFF_BIT_DEPTH,
    localparam int ACC_W  = ((PROD_W > BIAS_BIT_DEPTH) ? PROD_W : BIAS_BIT_DEPTH)
                            + $clog2(FEATURES + 1)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [FEATURES*FEATURE_BIT_DEPTH-1:0] in_features,
    input  logic                                  load_bias,
    input  logic                                  term_valid,
    input  logic [COEFF_BIT_DEPTH-1:0]            coeff,
    input  logic                                  is_one,
    input  logic [BIAS_BIT_DEPTH-1:0]             bias,
    input  logic                                  cluster_done,
    output logic                                  child_direction,
    output logic                                  decision_valid,
    output logic [ACC_W-1:0]                      acc_out,
    output logic                                  protocol_error
);

    localparam int FBD   = FEATURE_BIT_DEPTH;
    localparam int IDX_W = (FEATURES > 1) ? $clog2(FEATURES) : 1;

    typedef enum logic [1:0] {IDLE, HOLD, ACCUM} state_t;

    state_t                      state, state_nxt;
    logic [FEATURES*FBD-1:0]     feat_q;
    logic [ACC_W-1:0]            acc;
    logic [IDX_W-1:0]            idx, term_idx;
    logic [FBD-1:0]              sel_feat;
    logic signed [PROD_W-1:0]    prod;
    logic [ACC_W-1:0]            term, base, next_sum;
    logic                        take_term, last_term, err_cond;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (in_valid) state_nxt = HOLD;
            HOLD:  if (cluster_done)   state_nxt = IDLE;
                   else if (take_term) state_nxt = last_term ? HOLD : ACCUM;
            ACCUM: if (cluster_done)   state_nxt = IDLE;
                   else if (take_term && last_term) state_nxt = HOLD;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE);
    end

    // load_bias always consumes term 0, including a restart from ACCUM
    always_comb begin
        term_idx = load_bias ? '0 : idx;
        sel_feat = '0;
        for (int unsigned k = 0; k < FEATURES; k++) begin
            if (term_idx == IDX_W'(k)) sel_feat = feat_q[k*FBD +: FBD];
        end
        prod = $signed(sel_feat) * $signed(coeff);
        term = is_one ? {{(ACC_W-FBD){sel_feat[FBD-1]}}, sel_feat}
                      : {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        base = load_bias ? {{(ACC_W-BIAS_BIT_DEPTH){bias[BIAS_BIT_DEPTH-1]}}, bias} : acc;
        next_sum = base + term;

        take_term = ((state == HOLD) && load_bias && term_valid && !cluster_done)
                 || ((state == ACCUM) && term_valid);
        last_term = load_bias ? (FEATURES == 1) : (idx == IDX_W'(FEATURES - 1));

        err_cond = ((state == IDLE)  && (load_bias || term_valid))
                || ((state == HOLD)  && (load_bias != term_valid))
                || ((state == ACCUM) && load_bias);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            feat_q          <= '0;
            acc             <= '0;
            idx             <= '0;
            acc_out         <= '0;
            child_direction <= 1'b0;
            decision_valid  <= 1'b0;
            protocol_error  <= 1'b0;
        end else begin
            decision_valid <= 1'b0;
            protocol_error <= err_cond;
            if ((state == IDLE) && in_valid) feat_q <= in_features;
            if (take_term) begin
                acc <= next_sum;
                idx <= last_term ? '0 : (term_idx + IDX_W'(1));
                if (last_term) begin
                    acc_out         <= next_sum;
                    child_direction <= ~next_sum[ACC_W-1];
                    decision_valid  <= 1'b1;
                end
            end
            // an abort mid-node leaves no partial index behind
            if (cluster_done && (state == ACCUM) && !(take_term && last_term)) idx <= '0;
        end
    end

endmodule

// File: tb/tb_node_evaluator.sv
// Directed bench for node_evaluator: hand-computed sums, stalls, stream errors,
// aborts and reset behaviour with the default 3 x 8-bit configuration.
module tb_node_evaluator;

    localparam int FEATURES = 3;
    localparam int FBD      = 8;
    localparam int CBD      = 4;
    localparam int BBD      = 10;
    localparam int ACC_W    = 14;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    in_valid;
    logic                    in_ready;
    logic [FEATURES*FBD-1:0] in_features;
    logic                    load_bias;
    logic                    term_valid;
    logic [CBD-1:0]          coeff;
    logic                    is_one;
    logic [BBD-1:0]          bias;
    logic                    cluster_done;
    logic                    child_direction;
    logic                    decision_valid;
    logic [ACC_W-1:0]        acc_out;
    logic                    protocol_error;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    node_evaluator #(
        .FEATURES(FEATURES),
        .FEATURE_BIT_DEPTH(FBD),
        .COEFF_BIT_DEPTH(CBD),
        .BIAS_BIT_DEPTH(BBD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_features(in_features),
        .load_bias(load_bias),
        .term_valid(term_valid),
        .coeff(coeff),
        .is_one(is_one),
        .bias(bias),
        .cluster_done(cluster_done),
        .child_direction(child_direction),
        .decision_valid(decision_valid),
        .acc_out(acc_out),
        .protocol_error(protocol_error)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [FEATURES*FBD-1:0] pack3(input int a, input int b, input int c);
        return {c[7:0], b[7:0], a[7:0]};
    endfunction

    task automatic drive_term(input logic lb, input logic one, input int c, input int b);
        load_bias  = lb;
        term_valid = 1'b1;
        is_one     = one;
        coeff      = c[CBD-1:0];
        bias       = b[BBD-1:0];
        tick();
        load_bias  = 1'b0;
        term_valid = 1'b0;
        is_one     = 1'b0;
    endtask

    task automatic check_result(input string tag, input int exp_acc, input logic exp_dir);
        chk({tag, "_dv"},  decision_valid, 1);
        chk({tag, "_acc"}, $signed(acc_out), exp_acc);
        chk({tag, "_dir"}, child_direction, exp_dir);
    endtask

    task automatic accept(input logic [FEATURES*FBD-1:0] v);
        in_features = v;
        in_valid    = 1'b1;
        tick();
        in_valid    = 1'b0;
        chk("accept_ready_low", in_ready, 0);
    endtask

    initial begin
        reset        = 1'b0;
        in_valid     = 1'b1;
        in_features  = pack3(10, -5, 3);
        load_bias    = 1'b0;
        term_valid   = 1'b0;
        coeff        = '0;
        is_one       = 1'b0;
        bias         = '0;
        cluster_done = 1'b0;

        tick();
        chk("rst_ready", in_ready, 1);
        chk("rst_dv", decision_valid, 0);
        chk("rst_perr", protocol_error, 0);
        chk("rst_acc", $signed(acc_out), 0);
        chk("rst_dir", child_direction, 0);
        tick();
        chk("rst_ready2", in_ready, 1);
        reset = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("first_accept", in_ready, 0);

        // (10,-5,3), bias -20: -20+10-10-3 = -23
        drive_term(1'b1, 1'b1, 0, -20);
        chk("n1_dv_e0", decision_valid, 0);
        drive_term(1'b0, 1'b0, 2, 0);
        chk("n1_dv_e1", decision_valid, 0);
        drive_term(1'b0, 1'b0, -1, 0);
        check_result("n1", -23, 1'b0);
        tick();
        chk("n1_dv_drop", decision_valid, 0);
        chk("n1_acc_hold", $signed(acc_out), -23);

        // bias 40, {-1, one, 7}: 40-10-5+21 = 46, three nodes on one vector
        for (int n = 0; n < 3; n++) begin
            drive_term(1'b1, 1'b0, -1, 40);
            drive_term(1'b0, 1'b1, 0, 0);
            drive_term(1'b0, 1'b0, 7, 0);
            check_result("n2", 46, 1'b1);
        end

        // release coincident with an offered vector: not taken until next cycle
        cluster_done = 1'b1;
        in_valid     = 1'b1;
        in_features  = pack3(-128, -128, -128);
        tick();
        cluster_done = 1'b0;
        chk("cd_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("cd_accept_next", in_ready, 0);

        // 511 + 3*1024 = 3583
        drive_term(1'b1, 1'b0, -8, 511);
        drive_term(1'b0, 1'b0, -8, 0);
        drive_term(1'b0, 1'b0, -8, 0);
        check_result("ext_pos", 3583, 1'b1);

        cluster_done = 1'b1;
        tick();
        cluster_done = 1'b0;
        accept(pack3(127, 127, 127));
        // -512 - 3*1016 = -3560
        drive_term(1'b1, 1'b0, -8, -512);
        drive_term(1'b0, 1'b0, -8, 0);
        drive_term(1'b0, 1'b0, -8, 0);
        check_result("ext_neg", -3560, 1'b0);

        // -100 + 254 - 127 + 127 = 154, unstalled then with a 2-cycle stall
        drive_term(1'b1, 1'b0, 2, -100);
        drive_term(1'b0, 1'b0, -1, 0);
        drive_term(1'b0, 1'b1, 0, 0);
        check_result("nostall", 154, 1'b1);
        drive_term(1'b1, 1'b0, 2, -100);
        drive_term(1'b0, 1'b0, -1, 0);
        tick();
        chk("stall_dv1", decision_valid, 0);
        tick();
        chk("stall_dv2", decision_valid, 0);
        drive_term(1'b0, 1'b1, 0, 0);
        check_result("stall", 154, 1'b1);

        // restart at index 1: 5 + 127 + 127 - 254 = 5
        drive_term(1'b1, 1'b0, 1, 0);
        drive_term(1'b1, 1'b0, 1, 5);
        chk("restart_perr", protocol_error, 1);
        chk("restart_dv", decision_valid, 0);
        drive_term(1'b0, 1'b0, 1, 0);
        chk("restart_perr_clr", protocol_error, 0);
        drive_term(1'b0, 1'b0, -2, 0);
        check_result("restart", 5, 1'b1);

        // abort at index 1
        drive_term(1'b1, 1'b0, 1, 0);
        cluster_done = 1'b1;
        tick();
        cluster_done = 1'b0;
        chk("abort_ready", in_ready, 1);
        chk("abort_dv", decision_valid, 0);
        drive_term(1'b0, 1'b0, 1, 0);
        chk("idle_term_perr", protocol_error, 1);
        chk("idle_term_ready", in_ready, 1);
        chk("idle_term_dv", decision_valid, 0);
        chk("idle_acc_hold", $signed(acc_out), 5);

        // stray term in HOLD is ignored; last term coincident with cluster_done completes
        accept(pack3(10, -5, 3));
        drive_term(1'b0, 1'b0, 3, 0);
        chk("hold_term_perr", protocol_error, 1);
        chk("hold_term_dv", decision_valid, 0);
        drive_term(1'b1, 1'b1, 0, -20);
        drive_term(1'b0, 1'b0, 2, 0);
        cluster_done = 1'b1;
        drive_term(1'b0, 1'b0, -1, 0);
        cluster_done = 1'b0;
        check_result("cd_last", -23, 1'b0);
        chk("cd_last_ready", in_ready, 1);

        // reset mid-accumulation
        accept(pack3(10, -5, 3));
        drive_term(1'b1, 1'b1, 0, 40);
        reset = 1'b0;
        #1;
        chk("midrst_ready", in_ready, 1);
        chk("midrst_acc", $signed(acc_out), 0);
        chk("midrst_dir", child_direction, 0);
        tick();
        reset = 1'b1;
        tick();
        chk("midrst_idle", in_ready, 1);
        chk("midrst_dv", decision_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
